// File: rtl/alu_pkg.sv
// ALU operation encoding shared by decode, the ID/EX stage and the ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    AND  = 4'd2,
    OR   = 4'd3,
    XOR  = 4'd4,
    SLL  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    SLT  = 4'd8,
    SLTU = 4'd9
  } alu_op_t;

endpackage

// File: rtl/pipe_pkg.sv
// Pipeline-wide types: forwarding select and the ID/EX register payload with its bubble value.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    alu_pkg::alu_op_t      alu_op;
    logic [REG_AW-1:0]     rs1;
    logic [REG_AW-1:0]     rs2;
    logic                  rs1_en;
    logic                  rs2_en;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       imm;
    logic                  use_pc;
    logic                  use_imm;
    logic [REG_AW-1:0]     rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } id_ex_t;

  // A bubble is indistinguishable from the reset state: invalid, no enables, ADD.
  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:     1'b0,
    alu_op:    alu_pkg::ADD,
    rs1:       '0,
    rs2:       '0,
    rs1_en:    1'b0,
    rs2_en:    1'b0,
    rs1_data:  '0,
    rs2_data:  '0,
    pc:        '0,
    imm:       '0,
    use_pc:    1'b0,
    use_imm:   1'b0,
    rd:        '0,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Forwarding source select for one EX source operand; MEM wins over WB, x0 never forwards.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] rs_i,
  input  logic                      rs_en_i,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                      mem_we_i,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_i,
  input  logic                      wb_we_i,
  output fwd_sel_t                  sel_o
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_we_i && (mem_rd_i != '0) && (mem_rd_i == rs_i);
  assign wb_hit  = wb_we_i  && (wb_rd_i  != '0) && (wb_rd_i  == rs_i);

  always_comb begin
    // NOTE: sel_o gets a default before any branch so no path leaves it unassigned (no latch).
    sel_o = FWD_NONE;
    if (rs_en_i) begin
      if (mem_hit)     sel_o = FWD_MEM;
      else if (wb_hit) sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use detection, stall, flush and bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = pipe_pkg::XLEN,
  parameter int unsigned REG_ADDR_WIDTH = pipe_pkg::REG_AW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          id_valid,
  input  alu_pkg::alu_op_t              id_alu_op,
  input  logic [REG_ADDR_WIDTH-1:0]     id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]     id_rs2,
  input  logic                          id_rs1_en,
  input  logic                          id_rs2_en,
  input  logic [DATA_WIDTH-1:0]         id_rs1_data,
  input  logic [DATA_WIDTH-1:0]         id_rs2_data,
  input  logic [DATA_WIDTH-1:0]         id_pc,
  input  logic [DATA_WIDTH-1:0]         id_imm,
  input  logic                          id_use_pc,
  input  logic                          id_use_imm,
  input  logic [REG_ADDR_WIDTH-1:0]     id_rd,
  input  logic                          id_reg_write,
  input  logic                          id_mem_read,
  input  logic                          id_mem_write,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [REG_ADDR_WIDTH-1:0]     mem_rd,
  input  logic                          mem_reg_write,
  input  logic [DATA_WIDTH-1:0]         mem_result,
  input  logic [REG_ADDR_WIDTH-1:0]     wb_rd,
  input  logic                          wb_reg_write,
  input  logic [DATA_WIDTH-1:0]         wb_result,
  output logic                          load_use_stall,
  output logic                          ex_valid,
  output alu_pkg::alu_op_t              ex_alu_op,
  output logic signed [DATA_WIDTH-1:0]  ex_opr_a,
  output logic signed [DATA_WIDTH-1:0]  ex_opr_b,
  output logic [DATA_WIDTH-1:0]         ex_store_data,
  output logic [REG_ADDR_WIDTH-1:0]     ex_rd,
  output logic                          ex_reg_write,
  output logic                          ex_mem_read,
  output logic                          ex_mem_write
);

  id_ex_t   ex_q, ex_d, id_pkt;
  fwd_sel_t fwd_a_sel, fwd_b_sel;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic rs1_dep, rs2_dep;

  assign rs1_dep = id_rs1_en && (id_rs1 == ex_q.rd);
  assign rs2_dep = id_rs2_en && (id_rs2 == ex_q.rd);
  // A flushed decode instruction never enters EX, so it cannot cause a hazard.
  assign load_use_stall = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0)
                          && (rs1_dep || rs2_dep) && !flush;

  always_comb begin
    id_pkt           = ID_EX_BUBBLE;
    id_pkt.valid     = id_valid;
    id_pkt.alu_op    = id_alu_op;
    id_pkt.rs1       = id_rs1;
    id_pkt.rs2       = id_rs2;
    id_pkt.rs1_en    = id_rs1_en;
    id_pkt.rs2_en    = id_rs2_en;
    id_pkt.rs1_data  = id_rs1_data;
    id_pkt.rs2_data  = id_rs2_data;
    id_pkt.pc        = id_pc;
    id_pkt.imm       = id_imm;
    id_pkt.use_pc    = id_use_pc;
    id_pkt.use_imm   = id_use_imm;
    id_pkt.rd        = id_rd;
    id_pkt.reg_write = id_reg_write && id_valid;
    id_pkt.mem_read  = id_mem_read  && id_valid;
    id_pkt.mem_write = id_mem_write && id_valid;
  end

  always_comb begin
    ex_d = ex_q;
    if (flush)               ex_d = ID_EX_BUBBLE;
    else if (stall)          ex_d = ex_q;
    else if (load_use_stall) ex_d = ID_EX_BUBBLE;
    else                     ex_d = id_pkt;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= ID_EX_BUBBLE;
    else     ex_q <= ex_d;
  end

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
    .rs_i     (ex_q.rs1),
    .rs_en_i  (ex_q.rs1_en),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_reg_write),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_reg_write),
    .sel_o    (fwd_a_sel)
  );

  fwd_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
    .rs_i     (ex_q.rs2),
    .rs_en_i  (ex_q.rs2_en),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_reg_write),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_reg_write),
    .sel_o    (fwd_b_sel)
  );

  always_comb begin
    unique case (fwd_a_sel)
      FWD_MEM: fwd_rs1 = mem_result;
      FWD_WB:  fwd_rs1 = wb_result;
      default: fwd_rs1 = ex_q.rs1_data;
    endcase
    unique case (fwd_b_sel)
      FWD_MEM: fwd_rs2 = mem_result;
      FWD_WB:  fwd_rs2 = wb_result;
      default: fwd_rs2 = ex_q.rs2_data;
    endcase
  end

  assign ex_valid      = ex_q.valid;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_opr_a      = ex_q.use_pc  ? ex_q.pc  : fwd_rs1;
  assign ex_opr_b      = ex_q.use_imm ? ex_q.imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: pass-through, forwarding priority, load-use, flush, stall.
module tb_id_ex_stage;
  import alu_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  alu_op_t          id_alu_op;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic             id_rs1_en, id_rs2_en;
  logic [31:0]      id_rs1_data, id_rs2_data, id_pc, id_imm;
  logic             id_use_pc, id_use_imm;
  logic             id_reg_write, id_mem_read, id_mem_write;
  logic             stall, flush;
  logic [4:0]       mem_rd, wb_rd;
  logic             mem_reg_write, wb_reg_write;
  logic [31:0]      mem_result, wb_result;
  logic             load_use_stall, ex_valid;
  alu_op_t          ex_alu_op;
  logic signed [31:0] ex_opr_a, ex_opr_b;
  logic [31:0]      ex_store_data;
  logic [4:0]       ex_rd;
  logic             ex_reg_write, ex_mem_read, ex_mem_write;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_alu_op(id_alu_op),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_pc(id_pc), .id_imm(id_imm), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write),
    .stall(stall), .flush(flush),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
    .ex_opr_a(ex_opr_a), .ex_opr_b(ex_opr_b), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clear();
    id_valid = 0; id_alu_op = ADD; id_rs1 = 0; id_rs2 = 0; id_rs1_en = 0; id_rs2_en = 0;
    id_rs1_data = 0; id_rs2_data = 0; id_pc = 0; id_imm = 0; id_use_pc = 0; id_use_imm = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
  endtask

  task automatic fwd_clear();
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
  endtask

  task automatic id_load_r4();
    id_clear();
    id_valid = 1; id_rs1 = 1; id_rs1_en = 1; id_rs1_data = 32'h1000;
    id_use_imm = 1; id_imm = 32'h4; id_rd = 4; id_reg_write = 1; id_mem_read = 1;
  endtask

  task automatic id_sub_dep_r4();
    id_clear();
    id_valid = 1; id_alu_op = SUB; id_rs1 = 5; id_rs1_en = 1; id_rs1_data = 32'h50;
    id_rs2 = 4; id_rs2_en = 1; id_rs2_data = 32'hDEAD; id_rd = 7; id_reg_write = 1;
  endtask

  initial begin
    rst = 1; stall = 0; flush = 0;
    id_clear();
    fwd_clear();
    tick();
    tick();
    check("rst_valid", ex_valid, 0);
    check("rst_op", ex_alu_op, ADD);
    check("rst_opr_a", ex_opr_a, 0);
    check("rst_rd", ex_rd, 0);
    check("rst_rw", ex_reg_write, 0);
    check("rst_lus", load_use_stall, 0);
    rst = 0;

    // Plain pass-through of an ADD
    id_valid = 1; id_alu_op = ADD; id_rs1 = 1; id_rs2 = 2; id_rs1_en = 1; id_rs2_en = 1;
    id_rs1_data = 5; id_rs2_data = 7; id_rd = 6; id_reg_write = 1;
    tick();
    check("pt_valid", ex_valid, 1);
    check("pt_opr_a", ex_opr_a, 5);
    check("pt_opr_b", ex_opr_b, 7);
    check("pt_op", ex_alu_op, ADD);
    check("pt_rd", ex_rd, 6);
    check("pt_rw", ex_reg_write, 1);
    check("pt_store", ex_store_data, 7);

    // Invalid decode slot must not carry write enables
    id_valid = 0;
    tick();
    check("inv_valid", ex_valid, 0);
    check("inv_rw", ex_reg_write, 0);

    // MEM beats WB, then WB alone, then no forward
    id_clear();
    id_valid = 1; id_alu_op = OR; id_rs1 = 3; id_rs1_en = 1; id_rs1_data = 32'h33;
    id_use_imm = 1; id_imm = 32'h10;
    tick();
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'h11;
    wb_rd = 3; wb_reg_write = 1; wb_result = 32'h22;
    #1;
    check("fwd_mem_pri", ex_opr_a, 32'h11);
    check("fwd_imm_b", ex_opr_b, 32'h10);
    check("fwd_op", ex_alu_op, OR);
    mem_reg_write = 0;
    #1;
    check("fwd_wb", ex_opr_a, 32'h22);
    wb_reg_write = 0;
    #1;
    check("fwd_none", ex_opr_a, 32'h33);

    // x0 never forwarded; rs2 via WB shows on store data while opr_b takes imm
    fwd_clear();
    id_clear();
    id_valid = 1; id_rs1 = 0; id_rs1_en = 1; id_rs1_data = 0;
    id_rs2 = 2; id_rs2_en = 1; id_rs2_data = 32'h9; id_use_imm = 1; id_imm = 32'h8;
    id_mem_write = 1;
    tick();
    mem_rd = 0; mem_reg_write = 1; mem_result = 32'hFF;
    wb_rd = 2; wb_reg_write = 1; wb_result = 32'h44;
    #1;
    check("x0_opr_a", ex_opr_a, 0);
    check("st_opr_b", ex_opr_b, 32'h8);
    check("st_data", ex_store_data, 32'h44);
    check("st_mw", ex_mem_write, 1);

    // PC as operand A
    fwd_clear();
    id_clear();
    id_valid = 1; id_use_pc = 1; id_pc = 32'h200; id_rs1 = 1; id_rs1_en = 1; id_rs1_data = 32'h77;
    tick();
    check("pc_opr_a", ex_opr_a, 32'h200);

    // Load-use: bubble, then dependent SUB gets the load value from WB
    id_load_r4();
    tick();
    check("lu_ld_mr", ex_mem_read, 1);
    id_sub_dep_r4();
    #1;
    check("lu_detect", load_use_stall, 1);
    tick();
    check("lu_bubble", ex_valid, 0);
    check("lu_bubble_rw", ex_reg_write, 0);
    check("lu_released", load_use_stall, 0);
    mem_rd = 4; mem_reg_write = 1; mem_result = 32'h1004;
    tick();
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 4; wb_reg_write = 1; wb_result = 32'hCAFE;
    #1;
    check("lu_sub_valid", ex_valid, 1);
    check("lu_sub_op", ex_alu_op, SUB);
    check("lu_sub_a", ex_opr_a, 32'h50);
    check("lu_sub_b", ex_opr_b, 32'hCAFE);
    check("lu_sub_rd", ex_rd, 7);
    fwd_clear();

    // Flush beats the hazard
    id_load_r4();
    tick();
    id_sub_dep_r4();
    flush = 1;
    #1;
    check("fl_no_lus", load_use_stall, 0);
    tick();
    flush = 0;
    id_clear();
    check("fl_valid", ex_valid, 0);
    check("fl_rw", ex_reg_write, 0);
    check("fl_rd", ex_rd, 0);

    // Stall holds for 3 cycles while decode changes; forwarding stays live
    id_valid = 1; id_alu_op = AND; id_rs1 = 8; id_rs1_en = 1; id_rs1_data = 32'h80;
    id_rs2 = 9; id_rs2_en = 1; id_rs2_data = 32'h90; id_rd = 10; id_reg_write = 1;
    tick();
    check("st0_a", ex_opr_a, 32'h80);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      id_alu_op = XOR; id_rs1_data = 32'h1 + i; id_rs2_data = 32'h2 + i; id_rd = 5'(11 + i);
      tick();
      check("stall_op", ex_alu_op, AND);
      check("stall_rd", ex_rd, 10);
      check("stall_b", ex_opr_b, 32'h90);
      check("stall_valid", ex_valid, 1);
      if (i == 1) begin
        mem_rd = 8; mem_reg_write = 1; mem_result = 32'h1234;
        #1;
        check("stall_fwd_a", ex_opr_a, 32'h1234);
      end
    end
    fwd_clear();
    #1;
    check("stall_held_a", ex_opr_a, 32'h80);

    // Reset while stalled wins
    rst = 1;
    tick();
    rst = 0; stall = 0;
    check("rst_stall_valid", ex_valid, 0);
    check("rst_stall_rd", ex_rd, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
ID/EX pipeline stage of the core.
- Registers decoded instruction fields from decode.
- Resolves operand forwarding from the MEM and WB stages.
- Detects load-use hazards.
- Drives op/opr_a/opr_b straight into the ALU; EX-stage result capture is downstream of this block.
- Handles stall (hold), flush (kill) and hazard bubble insertion.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_ADDR_WIDTH, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- id_alu_op  in  alu_op_t  decoded ALU operation.
- id_rs1, id_rs2  in  REG_ADDR_WIDTH  source register indices.
- id_rs1_en, id_rs2_en  in  1  instruction actually reads rs1/rs2.
- id_rs1_data, id_rs2_data  in  DATA_WIDTH  register-file read data.
- id_pc, id_imm  in  DATA_WIDTH  instruction PC, sign-extended immediate.
- id_use_pc  in  1  opr_a = pc.
- id_use_imm  in  1  opr_b = imm.
- id_rd  in  REG_ADDR_WIDTH  destination index.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- stall  in  1  downstream stall: hold stage contents.
- flush  in  1  branch/exception kill of the instruction entering EX.
- mem_rd  in  REG_ADDR_WIDTH; mem_reg_write  in  1; mem_result  in  DATA_WIDTH  EX/MEM forwarding source.
- wb_rd  in  REG_ADDR_WIDTH; wb_reg_write  in  1; wb_result  in  DATA_WIDTH  MEM/WB forwarding source.
- load_use_stall  out  1  to fetch/decode: freeze IF/ID this cycle.
- ex_valid  out  1  EX stage holds a valid instruction.
- ex_alu_op  out  alu_op_t  to ALU op.
- ex_opr_a, ex_opr_b  out  DATA_WIDTH signed  to ALU operands.
- ex_store_data  out  DATA_WIDTH  forwarded rs2 for stores.
- ex_rd  out  REG_ADDR_WIDTH; ex_reg_write, ex_mem_read, ex_mem_write  out  1  pass-through controls.

Behaviour:
- Reset (rst high at clk edge): all registered fields zero, ex_alu_op = alu_pkg::ADD, ex_valid = 0. Reset mid-stall/flush wins over everything.
- Update priority per edge: rst > flush > stall > load_use_stall > normal load.
- flush: register loads a bubble = reset values, ex_valid = 0, no write enables.
- stall (no flush): all registers hold; outputs are recomputed combinationally from the held fields.
- load_use_stall (no stall/flush): register loads a bubble; decode holds its instruction, so it re-presents next cycle.
- Normal: register captures all id_* fields, ex_valid = id_valid. Control bits are ANDed with id_valid.
- Hazard detect (combinational): load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((id_rs1_en & id_rs1 == ex_rd) | (id_rs2_en & id_rs2 == ex_rd)) & ~flush.
- Forwarding (combinational, per source operand, on registered rs index and rs_en):
  - MEM match: mem_reg_write & mem_rd != 0 & mem_rd == rs → mem_result.
  - Else WB match (same conditions on wb_*) → wb_result.
  - Else registered rs data.
  - MEM has priority over WB; x0 is never forwarded.
- Operand select: ex_opr_a = use_pc ? pc : fwd_rs1; ex_opr_b = use_imm ? imm : fwd_rs2; ex_store_data = fwd_rs2 always.
- Latency: one cycle from id_* to ex_*. Operands are combinational from registers plus forwarding inputs, with no additional cycle.
- Forwarding also applies while held by stall, so values that complete during the stall are picked up.

Decomposition:
- pipe_pkg: fwd_sel_t enum {FWD_NONE, FWD_MEM, FWD_WB}; struct id_ex_t bundling all registered fields, with a bubble constant.
- alu_op_t is reused from alu_pkg.
- Sub-module fwd_unit: combinational, one per source operand, instantiated twice. Inputs rs, rs_en, mem/wb rd/we; outputs fwd_sel_t.

Test Plan:
- Reset and pass-through: rst 1 cycle, then id ADD, rs1_data=5, rs2_data=7 → next cycle ex_valid=1, ex_opr_a=5, ex_opr_b=7, ex_alu_op=ADD.
- MEM beats WB: ex rs1=3; mem_rd=3/mem_result=0x11 and wb_rd=3/wb_result=0x22 both writing → ex_opr_a=0x11. Drop mem_reg_write → 0x22.
- x0 never forwarded: rs1=0, mem_rd=0, mem_reg_write=1, mem_result=0xFF, rs1_data=0 → ex_opr_a=0.
- Load-use: ex holds load rd=4; id SUB rs2=4, rs2_en=1 → load_use_stall=1; next cycle ex_valid=0. Following cycle ex holds the SUB, with rs2 forwarded from WB.
- Flush vs hazard: same load-use setup with flush=1 → load_use_stall=0, next ex_valid=0, ex_reg_write=0.
- Stall hold: stall=1 for 3 cycles with changing id_* → ex_* fields unchanged. mem_result change on a matching rd is reflected on ex_opr_a within the same cycle.
